// File: rtl/vga_pixpost_pkg.sv
// Shared types for the VGA pixel post-processor: mode encoding and checksum width.
package vga_pixpost_pkg;

    typedef enum logic [1:0] {
        MODE_PASS = 2'd0,
        MODE_INV  = 2'd1,
        MODE_REV  = 2'd2,
        MODE_BARS = 2'd3
    } mode_t;

    localparam int CKSUM_W = 32;

endpackage

// File: rtl/vga_pixel_post_sync_edge.sv
// Registered edge detector: lvl is the input delayed one cycle; asrt/deas pulse
// in the same cycle lvl first shows the new level (POL = active level).
module vga_sync_edge #(
    parameter logic POL = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic sig,
    output logic lvl,
    output logic asrt,
    output logic deas
);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lvl  <= ~POL;
            asrt <= 1'b0;
            deas <= 1'b0;
        end else begin
            asrt <= (sig == POL) && (lvl != POL);
            deas <= (sig != POL) && (lvl == POL);
            lvl  <= sig;
        end
    end

endmodule

// File: rtl/vga_pixel_post.sv
// Two-stage pixel post-processor (pass/invert/reverse/bars) with x/y tracking.
// Optional frame checksum on o_cksum when VGA_PIXPOST_CKSUM_EN is defined.
module vga_pixel_post
    import vga_pixpost_pkg::*;
#(
    parameter int   CW       = 8,
    parameter int   NCH      = 3,
    parameter int   FW       = 13,
    parameter int   LW       = 11,
    parameter int   BARSHIFT = 6,
    parameter logic SYNC_POL = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    input  logic [1:0]            i_mode,
    input  logic                  i_hsync,
    input  logic                  i_vsync,
    input  logic                  i_de,
    input  logic [NCH*CW-1:0]     i_pix,
    output logic                  o_hsync,
    output logic                  o_vsync,
    output logic                  o_de,
    output logic [NCH*CW-1:0]     o_pix,
    output logic [FW-1:0]         o_x,
    output logic [LW-1:0]         o_y,
    output logic                  o_frame_start,
    output logic [CKSUM_W-1:0]    o_cksum
);

    localparam int PW = NCH * CW;

    logic                     s1_hs;
    logic [NCH-1:0][CW-1:0]   s1_pix;
    mode_t                    s1_mode;
    logic                     s1_vs, vs_asrt, unused_vs_deas;
    logic                     s1_de, de_fall, unused_de_rise;

    vga_sync_edge #(.POL(SYNC_POL)) u_vs_edge (
        .clk(i_clk), .reset_n(i_reset_n), .sig(i_vsync),
        .lvl(s1_vs), .asrt(vs_asrt), .deas(unused_vs_deas)
    );

    vga_sync_edge #(.POL(1'b1)) u_de_edge (
        .clk(i_clk), .reset_n(i_reset_n), .sig(i_de),
        .lvl(s1_de), .asrt(unused_de_rise), .deas(de_fall)
    );

    mode_t                  mode_q, mode_use;
    logic [FW-1:0]          x_cnt, x_pix;
    logic [LW-1:0]          y_cnt, y_pix;
    logic [2:0]             bar;
    logic [NCH-1:0][CW-1:0] pix_out;

    // A pixel arriving with the vsync edge already belongs to the new frame.
    always_comb begin
        x_pix    = vs_asrt ? '0 : x_cnt;
        y_pix    = vs_asrt ? '0 : y_cnt;
        mode_use = vs_asrt ? s1_mode : mode_q;
    end

    assign bar = 3'(x_pix >> BARSHIFT);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        assign pix_out[k] = (mode_use == MODE_INV)  ? ~s1_pix[k] :
                            (mode_use == MODE_REV)  ? s1_pix[NCH-1-k] :
                            (mode_use == MODE_BARS) ? {CW{bar[k % 3]}} :
                                                      s1_pix[k];
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            s1_hs         <= ~SYNC_POL;
            s1_pix        <= '0;
            s1_mode       <= MODE_PASS;
            o_hsync       <= ~SYNC_POL;
            o_vsync       <= ~SYNC_POL;
            o_de          <= 1'b0;
            o_pix         <= '0;
            o_x           <= '0;
            o_y           <= '0;
            o_frame_start <= 1'b0;
            mode_q        <= MODE_PASS;
            x_cnt         <= '0;
            y_cnt         <= '0;
        end else begin
            s1_hs         <= i_hsync;
            s1_pix        <= i_pix;
            s1_mode       <= mode_t'(i_mode);
            o_hsync       <= s1_hs;
            o_vsync       <= s1_vs;
            o_de          <= s1_de;
            o_pix         <= s1_de ? pix_out : '0;
            o_x           <= x_pix;
            o_y           <= y_pix;
            o_frame_start <= vs_asrt;
            if (vs_asrt)
                mode_q <= s1_mode;
            // Counters saturate; the vsync clear takes priority over a DE fall.
            if (vs_asrt) begin
                x_cnt <= FW'(s1_de);
                y_cnt <= '0;
            end else if (de_fall) begin
                x_cnt <= '0;
                if (~&y_cnt)
                    y_cnt <= y_cnt + LW'(1);
            end else if (s1_de && ~&x_cnt) begin
                x_cnt <= x_cnt + FW'(1);
            end
        end
    end

`ifdef VGA_PIXPOST_CKSUM_EN
    logic [PW-1:0]      pix_flat;
    logic [CKSUM_W-1:0] pix_ext, acc;

    assign pix_flat = pix_out;
    assign pix_ext  = s1_de ? CKSUM_W'(pix_flat) : '0;

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            acc     <= '0;
            o_cksum <= '0;
        end else if (vs_asrt) begin
            o_cksum <= acc;
            acc     <= pix_ext;
        end else begin
            acc <= acc + pix_ext;
        end
    end
`else
    assign o_cksum = '0;
`endif

endmodule

// File: tb/tb_vga_pixel_post.sv
// Scoreboard bench: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_vga_pixel_post;
    import vga_pixpost_pkg::*;

    localparam int   CW = 8, NCH = 3, PW = 24, FW = 13, LW = 11, BARSHIFT = 6;
    localparam logic POL = 1'b0;

    logic clk = 1'b0;
    logic i_reset_n = 1'b0, i_hsync = 1'b1, i_vsync = 1'b1, i_de = 1'b0;
    logic [1:0] i_mode = 2'd0;
    logic [PW-1:0] i_pix = '0;
    logic o_hsync, o_vsync, o_de, o_frame_start;
    logic [PW-1:0] o_pix;
    logic [FW-1:0] o_x;
    logic [LW-1:0] o_y;
    logic [31:0] o_cksum;

    vga_pixel_post #(.CW(CW), .NCH(NCH), .FW(FW), .LW(LW), .BARSHIFT(BARSHIFT), .SYNC_POL(POL)) dut (
        .i_clk(clk), .i_reset_n(i_reset_n), .i_mode(i_mode), .i_hsync(i_hsync),
        .i_vsync(i_vsync), .i_de(i_de), .i_pix(i_pix), .o_hsync(o_hsync),
        .o_vsync(o_vsync), .o_de(o_de), .o_pix(o_pix), .o_x(o_x), .o_y(o_y),
        .o_frame_start(o_frame_start), .o_cksum(o_cksum)
    );

    always #5 clk = ~clk;

    typedef struct {
        int due;
        logic hs, vs, de, fs;
        logic [PW-1:0] pix;
        logic [FW-1:0] x;
        logic [LW-1:0] y;
        logic [31:0] ck;
    } exp_t;

    exp_t q[$];
    int cyc = 0, checks = 0, failures = 0;
    bit in_rst = 0;

    // reference state
    logic m_prev_vs, m_prev_de;
    int   m_mode, m_x, m_y;
    logic [31:0] m_acc, m_ck;

    always @(posedge clk) cyc++;

    function automatic logic [1:0] rm();
        return 2'($urandom);
    endfunction

    function automatic logic [PW-1:0] rp();
        return PW'($urandom);
    endfunction

    function automatic logic [PW-1:0] ref_pix(input int m, input logic [PW-1:0] p, input int x);
        logic [PW-1:0] r;
        int b;
        r = '0;
        b = (x / (1 << BARSHIFT)) % 8;
        case (m)
            0: r = p;
            1: r = ~p;
            2: r = {p[7:0], p[15:8], p[23:16]};
            default: for (int k = 0; k < NCH; k++)
                         if (((b >> (k % 3)) & 1) == 1) r = r | (PW'(8'hFF) << (8 * k));
        endcase
        return r;
    endfunction

    task automatic step(input logic r, input logic h, input logic v, input logic d,
                        input logic [1:0] md, input logic [PW-1:0] p);
        exp_t e;
        logic ve, df;
        int mu, xp, yp;
        logic [PW-1:0] pout;
        @(posedge clk); #1;
        i_reset_n = r; i_hsync = h; i_vsync = v; i_de = d; i_mode = md; i_pix = p;
        e.due = cyc + 2;
        if (!r) begin
            m_prev_vs = ~POL; m_prev_de = 1'b0; m_mode = 0; m_x = 0; m_y = 0;
            m_acc = '0; m_ck = '0;
            e.hs = ~POL; e.vs = ~POL; e.de = 1'b0; e.fs = 1'b0; e.pix = '0;
            e.x = '0; e.y = '0; e.ck = '0;
            if (!in_rst) begin
                exp_t e1;
                e1 = e; e1.due = cyc + 1;
                q.push_back(e1);
            end
            in_rst = 1;
            q.push_back(e);
            return;
        end
        in_rst = 0;
        ve = (v == POL) && (m_prev_vs != POL);
        df = !d && m_prev_de;
        xp = ve ? 0 : m_x;
        yp = ve ? 0 : m_y;
        mu = ve ? int'(md) : m_mode;
        pout = d ? ref_pix(mu, p, xp) : '0;
`ifdef VGA_PIXPOST_CKSUM_EN
        if (ve) begin m_ck = m_acc; m_acc = 32'(pout); end
        else m_acc = m_acc + 32'(pout);
        e.ck = m_ck;
`else
        e.ck = '0;
`endif
        if (ve) begin
            m_mode = int'(md); m_x = d ? 1 : 0; m_y = 0;
        end else if (df) begin
            m_x = 0; if (m_y < (1 << LW) - 1) m_y++;
        end else if (d && m_x < (1 << FW) - 1) begin
            m_x++;
        end
        m_prev_vs = v; m_prev_de = d;
        e.hs = h; e.vs = v; e.de = d; e.fs = ve; e.pix = pout;
        e.x = FW'(xp); e.y = LW'(yp);
        q.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        while (q.size() > 0 && q[0].due <= cyc) begin
            e = q.pop_front();
            chk("hsync", 32'(o_hsync), 32'(e.hs));
            chk("vsync", 32'(o_vsync), 32'(e.vs));
            chk("de", 32'(o_de), 32'(e.de));
            chk("pix", 32'(o_pix), 32'(e.pix));
            chk("frame_start", 32'(o_frame_start), 32'(e.fs));
            chk("cksum", o_cksum, e.ck);
            if (e.de) begin
                chk("x", 32'(o_x), 32'(e.x));
                chk("y", 32'(o_y), 32'(e.y));
            end
        end
    end

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, ~POL, ~POL, 0, rm(), rp());
    endtask

    task automatic vpulse(input logic [1:0] md);
        step(1, ~POL, POL, 0, md, rp());
        step(1, ~POL, POL, 0, rm(), rp());
        idle(2);
    endtask

    task automatic line(input int npix, input logic fixed, input logic [PW-1:0] base);
        step(1, POL, ~POL, 0, rm(), rp());
        step(1, POL, ~POL, 0, rm(), rp());
        idle(2);
        for (int k = 0; k < npix; k++)
            step(1, ~POL, ~POL, 1, rm(), fixed ? base + PW'(k) : rp());
        idle(1);
    endtask

    initial begin
        repeat (4) step(0, 1'($urandom), 1'($urandom), 1'($urandom), rm(), rp());
        idle(3);
        // pass frame, 3 lines of 4 pixels; mode request scrambles mid-frame
        vpulse(MODE_PASS);
        for (int l = 0; l < 3; l++) line(4, 0, '0);
        // invert frame: first pixel 00FF0F
        vpulse(MODE_INV);
        line(1, 1, 24'h00FF0F);
        line(4, 0, '0);
        vpulse(MODE_REV);
        for (int l = 0; l < 2; l++) line(5, 0, '0);
        vpulse(MODE_BARS);
        line(640, 0, '0);
        // pixels 1..4 then vsync: checksum 10
        vpulse(MODE_PASS);
        line(4, 1, 24'h000001);
        vpulse(MODE_PASS);
        line(8200, 0, '0);
        // y saturation: many one-pixel lines
        vpulse(MODE_INV);
        for (int l = 0; l < 2100; l++) begin
            step(1, ~POL, ~POL, 1, rm(), rp());
            step(1, ~POL, ~POL, 0, rm(), rp());
        end
        // DE falling in the same cycle as the vsync edge
        vpulse(MODE_PASS);
        for (int k = 0; k < 3; k++) step(1, ~POL, ~POL, 1, rm(), rp());
        step(1, ~POL, POL, 0, MODE_REV, rp());
        step(1, ~POL, POL, 0, rm(), rp());
        line(3, 0, '0);
        for (int f = 0; f < 3; f++) begin
            vpulse(rm());
            for (int l = 0; l < int'($urandom_range(1, 4)); l++)
                line(int'($urandom_range(1, 20)), 0, '0);
        end
        vpulse(MODE_PASS);
        idle(4);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
